// File: rtl/trng_wb_ctrl.sv
// trng_wb_ctrl: Wishbone TRNG controller.
// Ring-oscillator bits are synchronized, XOR-combined into one bit per cycle,
// packed MSB-first into words and buffered in a small FIFO. A repetition-count
// health test stops sampling on a stuck source. Thermometer trims feed the
// oscillator macros.
module trng_wb_ctrl #(
  parameter int unsigned NUM_RO     = 2,
  parameter int unsigned TRIM_BITS  = 26,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REP_LIMIT  = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 rst_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [8:0]           wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  input  logic [NUM_RO-1:0]    ro_bits_i,
  output logic [TRIM_BITS-1:0] trim_fast_o,
  output logic [TRIM_BITS-1:0] trim_slow_o,
  output logic                 trng_valid_o,
  output logic                 health_fail_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned BW = $clog2(WORD_W);

  logic [NUM_RO-1:0] r_sync1, r_sync2;
  logic              r_enable;
  logic [4:0]        r_fast_code, r_slow_code;
  logic [WORD_W-2:0] r_acc;
  logic [BW-1:0]     r_bitcnt;
  logic [7:0]        r_rep;
  logic              r_last;
  logic              r_fail;
  logic [7:0]        r_ovf;
  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_rd_ptr, r_wr_ptr;
  logic [AW:0]       r_count;

  logic              w_req, w_rd, w_ctrl_wr, w_flush_cmd, w_clr;
  logic              w_c, w_sample, w_trip, w_flush, w_pop, w_push;
  logic              w_full, w_push_ok, w_drop;
  logic [7:0]        w_rep_next;
  logic [WORD_W-1:0] w_word;
  logic [4:0]        w_count5;
  logic [31:0]       w_rd_data;
  logic              w_unused;

  function automatic logic [TRIM_BITS-1:0] therm(input logic [4:0] code);
    logic [TRIM_BITS-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < TRIM_BITS; i++) t[i] = (i < 32'(code));
    return t;
  endfunction

  assign w_req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign w_rd        = w_req & ~wb_we_i;
  assign w_ctrl_wr   = w_req & wb_we_i & (wb_adr_i[3:2] == 2'd0);
  assign w_flush_cmd = w_ctrl_wr & wb_dat_i[1];
  assign w_clr       = w_ctrl_wr & wb_dat_i[2];

  assign w_c        = ^r_sync2;
  assign w_sample   = r_enable & ~r_fail;
  assign w_rep_next = ((r_rep == 8'd0) || (w_c != r_last)) ? 8'd1 : r_rep + 8'd1;
  assign w_trip     = w_sample && (w_rep_next == 8'(REP_LIMIT));
  assign w_flush    = w_flush_cmd | w_trip;
  assign w_word     = {r_acc, w_c};

  assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop     = w_rd && (wb_adr_i[3:2] == 2'd2) && (r_count != '0);
  assign w_push    = w_sample && (r_bitcnt == BW'(WORD_W-1)) && !w_flush;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;
  assign w_count5  = 5'(r_count);

  assign trng_valid_o  = (r_count != '0);
  assign health_fail_o = r_fail;

  assign w_unused = ^{wb_adr_i[8:4], wb_adr_i[1:0], wb_dat_i[31:17],
                      wb_dat_i[11:9], wb_dat_i[3]};

  // Register read multiplexer
  always_comb begin
    w_rd_data = '0;
    case (wb_adr_i[3:2])
      2'd0: w_rd_data = {15'b0, r_slow_code, 3'b0, r_fast_code, 3'b0, r_enable};
      2'd1: w_rd_data = {16'b0, r_ovf, w_count5[3:0], 1'b0, r_fail, w_full, trng_valid_o};
      2'd2: w_rd_data = (r_count != '0) ? 32'(r_mem[r_rd_ptr]) : '0;
      default: w_rd_data = 32'h54524E47;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge wb_clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_word;
  end

  // Bus handshake, control registers, sampling, health test and FIFO pointers
  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_enable    <= 1'b0;
      r_fast_code <= '0;
      r_slow_code <= 5'(TRIM_BITS);
      trim_fast_o <= '0;
      trim_slow_o <= '1;
      r_acc       <= '0;
      r_bitcnt    <= '0;
      r_rep       <= '0;
      r_last      <= 1'b0;
      r_fail      <= 1'b0;
      r_ovf       <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else begin
      wb_ack_o <= w_req;
      wb_dat_o <= w_rd ? w_rd_data : '0;
      r_sync1  <= ro_bits_i;
      r_sync2  <= r_sync1;

      if (w_ctrl_wr) begin
        r_enable    <= wb_dat_i[0];
        r_fast_code <= wb_dat_i[8:4];
        r_slow_code <= wb_dat_i[16:12];
        trim_fast_o <= therm(wb_dat_i[8:4]);
        trim_slow_o <= therm(wb_dat_i[16:12]);
      end

      if (w_sample) begin
        r_acc    <= w_word[WORD_W-2:0];
        r_bitcnt <= (r_bitcnt == BW'(WORD_W-1)) ? '0 : r_bitcnt + 1'b1;
        r_rep    <= w_rep_next;
        r_last   <= w_c;
      end

      // A trip on the same edge as clr_fail keeps the failure latched
      if (w_trip) r_fail <= 1'b1;
      else if (w_clr) begin
        r_fail <= 1'b0;
        r_rep  <= '0;
      end

      if (w_flush) begin
        r_acc    <= '0;
        r_bitcnt <= '0;
        r_ovf    <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push_ok, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        if (w_drop && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_trng_wb_ctrl.sv
// Directed testbench for trng_wb_ctrl with default parameters.
module tb_trng_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [8:0]  adr;
  logic [31:0] dat_i, dat_o;
  logic        ack;
  logic [1:0]  ro;
  logic [25:0] trim_fast, trim_slow;
  logic        valid, fail;

  logic        toggle_en = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] rd;
  int          n;

  trng_wb_ctrl #(.NUM_RO(2), .TRIM_BITS(26), .WORD_W(32), .FIFO_DEPTH(4), .REP_LIMIT(16)) dut (
    .wb_clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .ro_bits_i(ro), .trim_fast_o(trim_fast), .trim_slow_o(trim_slow),
    .trng_valid_o(valid), .health_fail_o(fail)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Oscillator stand-in: bit 0 toggles every cycle when enabled
  initial begin
    forever begin
      @(negedge clk);
      if (toggle_en) ro[0] = ~ro[0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {5'd0, a}; dat_i = d;
    @(negedge clk);
    chk("write_ack", {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {5'd0, a};
    @(negedge clk);
    chk("read_ack", {31'd0, ack}, 32'd1);
    d = dat_o;
    cyc = 1'b0; stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; ro = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_fail", {31'd0, fail}, 32'd0);
    chk("rst_trim_fast", 32'(trim_fast), 32'd0);
    chk("rst_trim_slow", 32'(trim_slow), 32'h03FFFFFF);
    wb_read(4'hC, rd); chk("id", rd, 32'h54524E47);
    wb_read(4'h0, rd); chk("rst_ctrl", rd, 32'h0001A000);
    @(negedge clk);
    chk("ack_single", {31'd0, ack}, 32'd0);
    chk("dat_idle", dat_o, 32'd0);

    // Trim encoding
    wb_write(4'h0, 32'h00003051);
    chk("trim_fast5", 32'(trim_fast), 32'h0000001F);
    chk("trim_slow3", 32'(trim_slow), 32'h00000007);
    wb_write(4'h0, 32'h000031F0);
    chk("trim_fast31", 32'(trim_fast), 32'h03FFFFFF);
    wb_read(4'h0, rd); chk("ctrl_rb", rd, 32'h000031F0);

    // Word capture: flush stale partial word, clear rep counter, then enable
    wb_write(4'h0, 32'h000031F6);
    toggle_en = 1'b1;
    repeat (3) @(negedge clk);
    wb_write(4'h0, 32'h000031F1);
    n = 0;
    while (!valid && n < 100) begin @(negedge clk); n++; end
    chk("word_latency", n, 32);
    wb_write(4'h0, 32'h000031F0);
    wb_read(4'h4, rd); chk("status_one", rd, 32'h00000011);
    wb_read(4'h8, rd); chk("data_alt", rd, rd[31] ? 32'hAAAAAAAA : 32'h55555555);
    wb_read(4'h4, rd); chk("status_empty", rd, 32'h00000000);

    // Overflow: 6 words into a 4-entry FIFO
    wb_write(4'h0, 32'h000031F3);
    repeat (192) @(negedge clk);
    wb_write(4'h0, 32'h000031F0);
    wb_read(4'h4, rd); chk("status_ovf", rd, 32'h00000243);
    for (int i = 0; i < 4; i++) begin
      wb_read(4'h8, rd); chk("ovf_data", rd, rd[31] ? 32'hAAAAAAAA : 32'h55555555);
    end
    wb_read(4'h8, rd); chk("empty_read", rd, 32'h00000000);
    chk("empty_valid", {31'd0, valid}, 32'd0);

    // Health failure on a stuck-at-0 source
    toggle_en = 1'b0; ro = 2'b00;
    repeat (3) @(negedge clk);
    wb_write(4'h0, 32'h000031F7);
    n = 0;
    while (!fail && n < 100) begin @(negedge clk); n++; end
    chk("trip_latency", n, 16);
    repeat (40) @(negedge clk);
    chk("fail_no_push", {31'd0, valid}, 32'd0);
    wb_read(4'h4, rd); chk("status_fail", rd, 32'h00000004);
    wb_write(4'h0, 32'h000031F5);
    chk("clr_fail", {31'd0, fail}, 32'd0);
    n = 0;
    while (!fail && n < 100) begin @(negedge clk); n++; end
    chk("resume_trip", n, 16);

    // Flush with 3 words buffered
    toggle_en = 1'b1;
    repeat (3) @(negedge clk);
    wb_write(4'h0, 32'h000031F7);
    repeat (96) @(negedge clk);
    wb_write(4'h0, 32'h000031F0);
    wb_read(4'h4, rd); chk("status_three", rd, 32'h00000031);
    wb_write(4'h0, 32'h000031F2);
    wb_read(4'h4, rd); chk("status_flushed", rd, 32'h00000000);

    // Reset during a DATA read request
    wb_write(4'h0, 32'h000031F1);
    repeat (40) @(negedge clk);
    chk("pre_rst_valid", {31'd0, valid}, 32'd1);
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 9'h008;
    @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_valid2", {31'd0, valid}, 32'd0);
    chk("rst_fail2", {31'd0, fail}, 32'd0);
    chk("rst_fast2", 32'(trim_fast), 32'd0);
    chk("rst_slow2", 32'(trim_slow), 32'h03FFFFFF);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; toggle_en = 1'b0;
    wb_read(4'h0, rd); chk("rst_ctrl2", rd, 32'h0001A000);
    wb_read(4'h4, rd); chk("rst_status2", rd, 32'h00000000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
